// File: rtl/incr_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | incr_arbiter_pkg : state encodings and default sizes for incr_arbiter       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package incr_arbiter_pkg;

   localparam int P_N_DEF = 4;
   localparam int P_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

endpackage : incr_arbiter_pkg

`default_nettype wire

// File: rtl/incr_arbiter_rr_picker.sv
// +----------------------------------------------------------------------------+
// | rr_picker : combinational round-robin pick, searching upward from ptr_i    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_picker
   import incr_arbiter_pkg::*;
#(
   parameter int P_N   = P_N_DEF,
   parameter int P_IDW = 2
) (
   input  logic [P_N-1:0]   req_i,
   input  logic [P_IDW-1:0] ptr_i,
   output logic [P_N-1:0]   gnt_o,
   output logic [P_IDW-1:0] idx_o,
   output logic             any_o
);

   logic [P_IDW-1:0] w_cand;

   // Index arithmetic wraps naturally because P_N is a power of two.
   always_comb begin
      gnt_o  = '0;
      idx_o  = '0;
      any_o  = 1'b0;
      w_cand = '0;
      for (int i = 0; i < P_N; i++) begin
         w_cand = ptr_i + P_IDW'(i);
         if (!any_o && req_i[w_cand]) begin
            any_o         = 1'b1;
            idx_o         = w_cand;
            gnt_o[w_cand] = 1'b1;
         end
      end
   end

endmodule : rr_picker

`default_nettype wire

// File: rtl/incr_arbiter.sv
// +----------------------------------------------------------------------------+
// | incr_arbiter : round-robin shared registered incrementer with overflow     |
// | Build option: INCR_ARB_SAT_EN saturates RESULT_O on overflow instead of    |
// | wrapping to zero.                                                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module incr_arbiter
   import incr_arbiter_pkg::*;
#(
   parameter int P_N   = P_N_DEF,
   parameter int P_W   = P_W_DEF,
   parameter int P_IDW = 2
) (
   input  logic             CLK_I,
   input  logic             RST_X,
   input  logic [P_N-1:0]   REQ_I,
   input  logic [P_N*P_W-1:0] DATA_I,
   output logic [P_N-1:0]   GNT_O,
   output logic [P_W-1:0]   RESULT_O,
   output logic [P_IDW-1:0] RESULT_ID_O,
   output logic             OVF_O,
   output logic             RESULT_VLD_O,
   input  logic             RESULT_RDY_I
);

   state_e           state_q, state_d;
   logic [P_IDW-1:0] ptr_q, ptr_d;
   logic [P_N-1:0]   gnt_q, gnt_d;
   logic [P_W-1:0]   op_q, op_d;
   logic [P_IDW-1:0] id_q, id_d;
   logic [P_W-1:0]   result_q, result_d;
   logic [P_IDW-1:0] rid_q, rid_d;
   logic             ovf_q, ovf_d;
   logic             vld_q, vld_d;

   logic [P_N-1:0]   w_pick_gnt;
   logic [P_IDW-1:0] w_pick_idx;
   logic             w_pick_any;
   logic [P_W-1:0]   w_pick_op;
   logic [P_W:0]     w_sum;
   logic [P_W-1:0]   w_res;

   rr_picker #(
      .P_N   (P_N),
      .P_IDW (P_IDW)
   ) u_picker (
      .req_i (REQ_I),
      .ptr_i (ptr_q),
      .gnt_o (w_pick_gnt),
      .idx_o (w_pick_idx),
      .any_o (w_pick_any)
   );

   always_comb begin
      w_pick_op = '0;
      for (int i = 0; i < P_N; i++) begin
         if (w_pick_gnt[i]) begin
            w_pick_op = DATA_I[i*P_W +: P_W];
         end
      end
   end

   assign w_sum = {1'b0, op_q} + {{P_W{1'b0}}, 1'b1};

`ifdef INCR_ARB_SAT_EN
   assign w_res = w_sum[P_W] ? {P_W{1'b1}} : w_sum[P_W-1:0];
`else
   assign w_res = w_sum[P_W-1:0];
`endif

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = '0;
      op_d     = op_q;
      id_d     = id_q;
      result_d = result_q;
      rid_d    = rid_q;
      ovf_d    = ovf_q;
      vld_d    = vld_q;
      case (state_q)
         ST_IDLE: begin
            if (w_pick_any) begin
               gnt_d   = w_pick_gnt;
               op_d    = w_pick_op;
               id_d    = w_pick_idx;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            result_d = w_res;
            ovf_d    = w_sum[P_W];
            rid_d    = id_q;
            vld_d    = 1'b1;
            state_d  = ST_OUT;
         end
         ST_OUT: begin
            if (RESULT_RDY_I) begin
               vld_d   = 1'b0;
               ptr_d   = id_q + P_IDW'(1);
               state_d = ST_IDLE;
            end
         end
         default: begin
            vld_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_I or negedge RST_X) begin
      if (!RST_X) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         gnt_q    <= '0;
         op_q     <= '0;
         id_q     <= '0;
         result_q <= '0;
         rid_q    <= '0;
         ovf_q    <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         op_q     <= op_d;
         id_q     <= id_d;
         result_q <= result_d;
         rid_q    <= rid_d;
         ovf_q    <= ovf_d;
         vld_q    <= vld_d;
      end
   end

   assign GNT_O        = gnt_q;
   assign RESULT_O     = result_q;
   assign RESULT_ID_O  = rid_q;
   assign OVF_O        = ovf_q;
   assign RESULT_VLD_O = vld_q;

endmodule : incr_arbiter

`default_nettype wire

// File: tb/tb_incr_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_incr_arbiter : directed scoreboard bench for incr_arbiter               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_incr_arbiter;

   logic        clk = 1'b0;
   logic        rst_x;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  gnt;
   logic [7:0]  result;
   logic [1:0]  result_id;
   logic        ovf;
   logic        vld;
   logic        rdy;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] res;
      logic       ovf;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   incr_arbiter u_dut (
      .CLK_I        (clk),
      .RST_X        (rst_x),
      .REQ_I        (req),
      .DATA_I       (data),
      .GNT_O        (gnt),
      .RESULT_O     (result),
      .RESULT_ID_O  (result_id),
      .OVF_O        (ovf),
      .RESULT_VLD_O (vld),
      .RESULT_RDY_I (rdy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] id, input logic [7:0] op);
      exp_t e;
      e.id  = id;
      e.ovf = (op == 8'hFF);
`ifdef INCR_ARB_SAT_EN
      e.res = (op == 8'hFF) ? 8'hFF : op + 8'd1;
`else
      e.res = op + 8'd1;
`endif
      return e;
   endfunction

   task automatic set_op(input int idx, input logic [7:0] op);
      data[idx*8 +: 8] = op;
   endtask

   task automatic expect_req(input int idx, input logic [7:0] op);
      set_op(idx, op);
      sb.push_back(model(2'(idx), op));
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      chk({tag, ".vld"}, 32'(vld), 32'd1);
      total++;
      assert (sb.size() > 0) else begin
         bad++;
         $error("FAIL %s.sb observed=empty expected=entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, ".res"}, 32'(result), 32'(e.res));
         chk({tag, ".id"},  32'(result_id), 32'(e.id));
         chk({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
      end
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, ".gnt"}, 32'(gnt), 32'd0);
      chk({tag, ".res"}, 32'(result), 32'd0);
      chk({tag, ".id"},  32'(result_id), 32'd0);
      chk({tag, ".ovf"}, 32'(ovf), 32'd0);
      chk({tag, ".vld"}, 32'(vld), 32'd0);
   endtask

   initial begin
      int order[5] = '{0, 1, 2, 3, 0};

      rst_x = 1'b0;
      req   = 4'b0000;
      data  = '0;
      rdy   = 1'b1;
      tick();
      tick();
      chk_reset_outs("reset");
      rst_x = 1'b1;

      // all four requesting, grants 3 cycles apart starting from ptr 0
      for (int i = 0; i < 4; i++) set_op(i, 8'h10 + 8'(i));
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         sb.push_back(model(2'(order[g]), 8'h10 + 8'(order[g])));
         tick();
         chk($sformatf("rr%0d.gnt", g), 32'(gnt), 32'(4'b0001 << order[g]));
         if (g == 4) req = 4'b0000;
         tick();
         chk($sformatf("rr%0d.gnt_off", g), 32'(gnt), 32'd0);
         pop_check($sformatf("rr%0d", g));
         tick();
         chk($sformatf("rr%0d.gap", g), 32'(gnt), 32'd0);
         chk($sformatf("rr%0d.acc", g), 32'(vld), 32'd0);
      end

      // overflow on requester 1 (ptr is now 1)
      expect_req(1, 8'hFF);
      req = 4'b0010;
      tick();
      chk("ovf.gnt", 32'(gnt), 32'b0010);
      req = 4'b0000;
      tick();
      pop_check("ovf");
      tick();

      // backpressure: requester 3 wins from ptr 2, requester 0 waits
      expect_req(3, 8'h7F);
      set_op(0, 8'h00);
      req = 4'b1001;
      rdy = 1'b0;
      tick();
      chk("bp.gnt", 32'(gnt), 32'b1000);
      req = 4'b0001;
      tick();
      pop_check("bp.first");
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("bp.hold%0d.vld", c), 32'(vld), 32'd1);
         chk($sformatf("bp.hold%0d.res", c), 32'(result), 32'h80);
         chk($sformatf("bp.hold%0d.gnt", c), 32'(gnt), 32'd0);
      end
      rdy = 1'b1;
      tick();
      chk("bp.acc.vld", 32'(vld), 32'd0);
      chk("bp.acc.gnt", 32'(gnt), 32'd0);
      sb.push_back(model(2'd0, 8'h00));
      tick();
      chk("bp.next.gnt", 32'(gnt), 32'b0001);
      req = 4'b0000;
      tick();
      pop_check("bp.next");
      tick();

      // reset during CALC discards the transaction; ptr returns to 0
      set_op(1, 8'h20);
      req = 4'b0010;
      tick();
      chk("rst.gnt", 32'(gnt), 32'b0010);
      #2;
      rst_x = 1'b0;
      sb.delete();
      #1;
      chk_reset_outs("rst.async");
      req = 4'b0100;
      tick();
      chk_reset_outs("rst.held");
      rst_x = 1'b1;
      expect_req(2, 8'h33);
      tick();
      chk("rst.regnt", 32'(gnt), 32'b0100);
      req = 4'b0000;
      tick();
      pop_check("rst.regnt");
      tick();

      // withdrawn request: requester 1 drops while requester 0 is in OUT
      expect_req(0, 8'h05);
      set_op(1, 8'h99);
      req = 4'b0011;
      rdy = 1'b0;
      tick();
      chk("wd.gnt", 32'(gnt), 32'b0001);
      req = 4'b0010;
      tick();
      pop_check("wd");
      req = 4'b0000;
      tick();
      rdy = 1'b1;
      tick();
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("wd.idle%0d.gnt", c), 32'(gnt), 32'd0);
         chk($sformatf("wd.idle%0d.vld", c), 32'(vld), 32'd0);
      end

      // RDY high with nothing valid has no effect
      chk("final.sb", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_incr_arbiter

`default_nettype wire
